ace_snoop_scheduler: RTL and testbench
======================================

Name: ace_snoop_scheduler

Overview:
Sequences ACE snoop transactions from the interconnect model to up to NUM_MASTERS cached masters. It broadcasts one snoop on the AC channel to a selected subset of masters and collects each master's CR response. It then merges the responses into one combined result for the home node. Only one snoop is in flight at a time; a per-snoop timeout guards against non-responding masters.

Parameters:
NUM_MASTERS, 4, number of snooped masters (1..16)
ADDR_WIDTH, 64, ACADDR width
TIMEOUT_CYCLES, 256, cycles allowed from snoop issue until all CR responses arrive (>=2)

Ports:
ACLK  input  1  clock; all logic rising-edge
ARESET  input  1  synchronous active-high reset
req_valid  input  1  snoop request valid
req_ready  output  1  scheduler can accept request
req_addr  input  ADDR_WIDTH  snoop address
req_snoop  input  4  ACSNOOP value
req_prot  input  3  ACPROT value
req_mask  input  NUM_MASTERS  bit i set = snoop master i
ac_valid  output  NUM_MASTERS  per-master ACVALID
ac_ready  input  NUM_MASTERS  per-master ACREADY
ac_addr  output  ADDR_WIDTH  shared ACADDR, registered request
ac_snoop  output  4  shared ACSNOOP
ac_prot  output  3  shared ACPROT
cr_valid  input  NUM_MASTERS  per-master CRVALID
cr_ready  output  NUM_MASTERS  per-master CRREADY
cr_resp  input  5*NUM_MASTERS  CRRESP, master i at [5i+4:5i]
rsp_valid  output  1  combined response valid
rsp_ready  input  1  combined response accepted
rsp_resp  output  5  merged CRRESP: [0]DataTransfer [1]Error [2]PassDirty [3]IsShared [4]WasUnique
rsp_src  output  4  lowest master index with DataTransfer=1; 0 if none
rsp_timeout  output  NUM_MASTERS  masters that missed the timeout

Behaviour:
- Reset values: req_ready=1 on the cycle after reset deasserts. During reset, req_ready=0. ac_valid=0, cr_ready=0, rsp_valid=0, rsp_resp=0, rsp_src=0, rsp_timeout=0, ac_addr/snoop/prot=0. State=IDLE; internal masks cleared.
- FSM states: IDLE, ISSUE, RESPOND.
- IDLE: req_ready=1. On req_valid at edge T:
  - Register addr/snoop/prot/mask.
  - Set ac_pend=req_mask and cr_pend=0.
  - Clear acc, rsp_src and timer.
  - If req_mask≠0: go to ISSUE, with ac_valid=ac_pend visible from T+1.
  - If req_mask=0: go to RESPOND, with rsp_valid=1 and rsp_resp=0 at T+1.
- ISSUE: req_ready=0; ac_valid=ac_pend; cr_ready=cr_pend.
  - AC handshake on master i (ac_valid[i]&ac_ready[i]): clear ac_pend[i], set cr_pend[i] next cycle.
  - CR handshake on master i (cr_ready[i]&cr_valid[i]): clear cr_pend[i].
    - acc |= cr_resp_i.
    - If cr_resp_i[0]=1 and no earlier DataTransfer has been recorded this snoop, rsp_src=i. For simultaneous DataTransfers, the lowest index wins.
  - cr_valid is ignored for masters whose cr_pend=0. cr_ready never asserts before that master's AC handshake.
  - When ac_pend=0 and cr_pend=0 after updates: go to RESPOND with rsp_valid=1 the next cycle.
  - Minimum latency: request accepted at T, AC handshake at T+1, CR handshake at T+2, rsp_valid at T+3.
- Timer: increments each ISSUE cycle. On reaching TIMEOUT_CYCLES-1:
  - rsp_timeout = ac_pend|cr_pend; acc[1] is forced to 1.
  - ac_pend and cr_pend are cleared; ac_valid and cr_ready drop next cycle.
  - Go to RESPOND.
  - A handshake completing on the timeout cycle counts; that master is excluded from rsp_timeout.
- RESPOND: rsp_valid=1; rsp_resp=acc; all ac_valid/cr_ready=0.
  - On rsp_ready: go to IDLE; rsp_valid=0 and req_ready=1 next cycle.
  - rsp_resp, rsp_src and rsp_timeout stay stable while rsp_valid=1 and rsp_ready=0.
- ac_valid[i], once asserted, stays high until the AC handshake or timeout; it is never retracted otherwise.
- ARESET mid-operation: next cycle all outputs take their reset values. The pending snoop is dropped with no response.

Test Plan:
- Mask=4'b0101, addr=64'h1000, snoop=4'h1. Masters 0 and 2 assert ac_ready at T+1 and return CRRESP 5'b01000 and 5'b00101 at T+2 -> rsp_valid at T+3, rsp_resp=5'b01101, rsp_src=2, rsp_timeout=0.
- Mask=4'b0000 -> rsp_valid at T+1 with rsp_resp=0, and no ac_valid ever asserted.
- Mask=4'b1111, all four return DataTransfer on the same cycle -> rsp_src=0.
- Master 3 holds ac_ready=0 for 10 cycles -> ac_valid[3] stays 1 with stable ac_addr. cr_ready[3] stays 0 until the AC handshake. Response is correct after completion.
- TIMEOUT_CYCLES=16, mask=4'b0011, master 1 never responds on CR -> after 16 ISSUE cycles, rsp_resp[1]=1 and rsp_timeout=4'b0010. rsp_valid is held for 3 cycles with rsp_ready=0; outputs stay stable.
- ARESET asserted in ISSUE with ac_valid=4'b0110 -> next cycle ac_valid=0, rsp_valid=0, req_ready=0. req_ready=1 on the first cycle after release; a new request then completes normally.

Source files
------------

// File: rtl/ace_snoop_scheduler.sv
// ACE snoop scheduler: broadcasts one snoop to a subset of masters, collects
// the CR responses and hands a single merged response back to the home node.
module ace_snoop_scheduler #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [3:0]               req_snoop,
  input  logic [2:0]               req_prot,
  input  logic [NUM_MASTERS-1:0]   req_mask,
  output logic [NUM_MASTERS-1:0]   ac_valid,
  input  logic [NUM_MASTERS-1:0]   ac_ready,
  output logic [ADDR_WIDTH-1:0]    ac_addr,
  output logic [3:0]               ac_snoop,
  output logic [2:0]               ac_prot,
  input  logic [NUM_MASTERS-1:0]   cr_valid,
  output logic [NUM_MASTERS-1:0]   cr_ready,
  input  logic [5*NUM_MASTERS-1:0] cr_resp,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [4:0]               rsp_resp,
  output logic [3:0]               rsp_src,
  output logic [NUM_MASTERS-1:0]   rsp_timeout
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [3:0]              snoop_q, snoop_nxt;
  logic [2:0]              prot_q, prot_nxt;
  logic [NUM_MASTERS-1:0]  ac_pend, ac_pend_nxt;
  logic [NUM_MASTERS-1:0]  cr_pend, cr_pend_nxt;
  logic [NUM_MASTERS-1:0]  tmo_q, tmo_nxt;
  logic [4:0]              acc, acc_nxt;
  logic [3:0]              src_q, src_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic                    req_ready_q, rsp_valid_q;
  logic [NUM_MASTERS-1:0]  ac_hs, cr_hs;
  logic                    dt_seen;

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign ac_valid    = ac_pend;
  assign cr_ready    = cr_pend;
  assign ac_addr     = addr_q;
  assign ac_snoop    = snoop_q;
  assign ac_prot     = prot_q;
  assign rsp_resp    = acc;
  assign rsp_src     = src_q;
  assign rsp_timeout = tmo_q;

  // State and datapath registers; every output is a flop.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      addr_q      <= '0;
      snoop_q     <= '0;
      prot_q      <= '0;
      ac_pend     <= '0;
      cr_pend     <= '0;
      tmo_q       <= '0;
      acc         <= '0;
      src_q       <= '0;
      timer       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      snoop_q     <= snoop_nxt;
      prot_q      <= prot_nxt;
      ac_pend     <= ac_pend_nxt;
      cr_pend     <= cr_pend_nxt;
      tmo_q       <= tmo_nxt;
      acc         <= acc_nxt;
      src_q       <= src_nxt;
      timer       <= timer_nxt;
      req_ready_q <= (state_nxt == IDLE);
      rsp_valid_q <= (state_nxt == RESPOND);
    end
  end

  // Next-state logic: accept, track per-master AC/CR progress, merge, time out.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    snoop_nxt   = snoop_q;
    prot_nxt    = prot_q;
    ac_pend_nxt = ac_pend;
    cr_pend_nxt = cr_pend;
    tmo_nxt     = tmo_q;
    acc_nxt     = acc;
    src_nxt     = src_q;
    timer_nxt   = timer;
    ac_hs       = ac_pend & ac_ready;
    cr_hs       = cr_pend & cr_valid;
    dt_seen     = acc[0];

    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_nxt    = req_addr;
          snoop_nxt   = req_snoop;
          prot_nxt    = req_prot;
          ac_pend_nxt = req_mask;
          cr_pend_nxt = '0;
          acc_nxt     = '0;
          src_nxt     = '0;
          tmo_nxt     = '0;
          timer_nxt   = '0;
          state_nxt   = (req_mask != '0) ? ISSUE : RESPOND;
        end
      end

      ISSUE: begin
        ac_pend_nxt = ac_pend & ~ac_hs;
        cr_pend_nxt = (cr_pend & ~cr_hs) | ac_hs;
        // Ascending scan so the lowest DataTransfer index claims rsp_src.
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
          if (cr_hs[i]) begin
            acc_nxt = acc_nxt | cr_resp[5*i +: 5];
            if (cr_resp[5*i] && !dt_seen) begin
              src_nxt = 4'(i);
              dt_seen = 1'b1;
            end
          end
        end
        timer_nxt = timer + TW'(1);
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_nxt     = ac_pend_nxt | cr_pend_nxt;
          acc_nxt[1]  = 1'b1;
          ac_pend_nxt = '0;
          cr_pend_nxt = '0;
          state_nxt   = RESPOND;
        end else if ((ac_pend_nxt == '0) && (cr_pend_nxt == '0)) begin
          state_nxt = RESPOND;
        end
      end

      RESPOND: begin
        if (rsp_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ace_snoop_scheduler.sv
// Directed bench for ace_snoop_scheduler with a 16-cycle snoop timeout.
module tb_ace_snoop_scheduler;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 64;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_snoop;
  logic [2:0]    req_prot;
  logic [NM-1:0] req_mask;
  logic [NM-1:0] ac_valid, ac_ready;
  logic [AW-1:0] ac_addr;
  logic [3:0]    ac_snoop;
  logic [2:0]    ac_prot;
  logic [NM-1:0] cr_valid, cr_ready;
  logic [5*NM-1:0] cr_resp;
  logic          rsp_valid, rsp_ready;
  logic [4:0]    rsp_resp;
  logic [3:0]    rsp_src;
  logic [NM-1:0] rsp_timeout;

  int errors = 0;
  int checks = 0;

  ace_snoop_scheduler #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_snoop(req_snoop), .req_prot(req_prot), .req_mask(req_mask),
    .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr),
    .ac_snoop(ac_snoop), .ac_prot(ac_prot),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_resp(cr_resp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_src(rsp_src), .rsp_timeout(rsp_timeout)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ARESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_snoop = '0; req_prot = '0;
    req_mask = '0; ac_ready = '0; cr_valid = '0; cr_resp = '0; rsp_ready = 1'b0;

    // Reset values
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ac_valid", ac_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_ac_addr", ac_addr, 0);
    ARESET = 1'b0;
    step();
    chk("post_rst_req_ready", req_ready, 1);

    // Mask 0101, minimum latency
    req_valid = 1'b1; req_mask = 4'b0101; req_addr = 64'h1000; req_snoop = 4'h1; req_prot = 3'h0;
    step();
    req_valid = 1'b0;
    chk("t1_ac_valid", ac_valid, 4'b0101);
    chk("t1_req_ready", req_ready, 0);
    chk("t1_ac_addr", ac_addr, 64'h1000);
    chk("t1_ac_snoop", ac_snoop, 4'h1);
    chk("t1_cr_ready0", cr_ready, 0);
    ac_ready = 4'b0101;
    step();
    ac_ready = 4'b0000;
    chk("t1_ac_done", ac_valid, 0);
    chk("t1_cr_ready", cr_ready, 4'b0101);
    chk("t1_rsp_early", rsp_valid, 0);
    cr_valid = 4'b0101;
    cr_resp = {5'b00000, 5'b00101, 5'b00000, 5'b01000};
    step();
    cr_valid = 4'b0000;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_resp", rsp_resp, 5'b01101);
    chk("t1_rsp_src", rsp_src, 2);
    chk("t1_rsp_timeout", rsp_timeout, 0);
    chk("t1_cr_ready_off", cr_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_req_ready", req_ready, 1);

    // Empty mask
    req_valid = 1'b1; req_mask = 4'b0000; req_addr = 64'h2222;
    step();
    req_valid = 1'b0;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_resp", rsp_resp, 0);
    chk("t2_rsp_src", rsp_src, 0);
    chk("t2_ac_valid", ac_valid, 0);
    chk("t2_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t2_ac_valid_after", ac_valid, 0);
    chk("t2_req_ready_after", req_ready, 1);

    // All four masters return DataTransfer together
    req_valid = 1'b1; req_mask = 4'b1111; req_addr = 64'h3000; req_snoop = 4'h2; ac_ready = 4'b1111;
    step();
    req_valid = 1'b0;
    chk("t3_ac_valid", ac_valid, 4'b1111);
    step();
    ac_ready = 4'b0000;
    chk("t3_cr_ready", cr_ready, 4'b1111);
    cr_valid = 4'b1111;
    cr_resp = {5'b00101, 5'b01001, 5'b10001, 5'b00001};
    step();
    cr_valid = 4'b0000;
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_resp", rsp_resp, 5'b11101);
    chk("t3_rsp_src", rsp_src, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Master 3 stalls its AC handshake for 10 cycles
    req_valid = 1'b1; req_mask = 4'b1001; req_addr = 64'hDEAD_BEEF_0000_0040;
    req_snoop = 4'h7; req_prot = 3'h2; ac_ready = 4'b0001;
    step();
    req_valid = 1'b0;
    chk("t4_ac_valid", ac_valid, 4'b1001);
    chk("t4_ac_prot", ac_prot, 3'h2);
    step();
    ac_ready = 4'b0000;
    chk("t4_ac_valid_m3", ac_valid, 4'b1000);
    chk("t4_cr_ready_m0", cr_ready, 4'b0001);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4_hold_ac_valid3", ac_valid[3], 1);
      chk("t4_hold_addr", ac_addr, 64'hDEAD_BEEF_0000_0040);
      chk("t4_hold_cr_ready3", cr_ready[3], 0);
    end
    ac_ready = 4'b1000;
    step();
    ac_ready = 4'b0000;
    chk("t4_cr_ready_both", cr_ready, 4'b1001);
    chk("t4_ac_valid_off", ac_valid, 0);
    cr_valid = 4'b1001;
    cr_resp = {5'b10001, 5'b00000, 5'b00000, 5'b01000};
    step();
    cr_valid = 4'b0000;
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_resp", rsp_resp, 5'b11001);
    chk("t4_rsp_src", rsp_src, 3);
    chk("t4_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Master 1 never answers on CR: timeout after 16 ISSUE cycles
    req_valid = 1'b1; req_mask = 4'b0011; req_addr = 64'h4000; req_snoop = 4'h3; ac_ready = 4'b0011;
    step();
    req_valid = 1'b0;
    step();
    ac_ready = 4'b0000;
    chk("t5_cr_ready", cr_ready, 4'b0011);
    cr_valid = 4'b0001;
    cr_resp = '0;
    step();
    cr_valid = 4'b0000;
    chk("t5_cr_ready_m1", cr_ready, 4'b0010);
    for (int k = 0; k < 13; k++) step();
    chk("t5_no_rsp_yet", rsp_valid, 0);
    chk("t5_cr_still", cr_ready, 4'b0010);
    step();
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_resp", rsp_resp, 5'b00010);
    chk("t5_rsp_timeout", rsp_timeout, 4'b0010);
    chk("t5_cr_ready_off", cr_ready, 0);
    chk("t5_ac_valid_off", ac_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_hold_valid", rsp_valid, 1);
      chk("t5_hold_resp", rsp_resp, 5'b00010);
      chk("t5_hold_timeout", rsp_timeout, 4'b0010);
      chk("t5_hold_src", rsp_src, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t5_done", rsp_valid, 0);
    chk("t5_req_ready", req_ready, 1);

    // Reset in the middle of ISSUE, then a clean request
    req_valid = 1'b1; req_mask = 4'b0110; req_addr = 64'h5000;
    step();
    req_valid = 1'b0;
    chk("t6_ac_valid", ac_valid, 4'b0110);
    ARESET = 1'b1;
    step();
    chk("t6_rst_ac_valid", ac_valid, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    ARESET = 1'b0;
    step();
    chk("t6_req_ready", req_ready, 1);
    chk("t6_ac_valid_idle", ac_valid, 0);
    req_valid = 1'b1; req_mask = 4'b0001; req_addr = 64'h2000; ac_ready = 4'b0001;
    step();
    req_valid = 1'b0;
    chk("t6_new_addr", ac_addr, 64'h2000);
    chk("t6_new_ac_valid", ac_valid, 4'b0001);
    step();
    ac_ready = 4'b0000;
    chk("t6_new_cr_ready", cr_ready, 4'b0001);
    cr_valid = 4'b0001;
    cr_resp = {5'b00000, 5'b00000, 5'b00000, 5'b00001};
    step();
    cr_valid = 4'b0000;
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_rsp_resp", rsp_resp, 5'b00001);
    chk("t6_rsp_src", rsp_src, 0);
    chk("t6_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t6_req_ready_end", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
